ps2_frame_controller: RTL and testbench
=======================================

PS2_FRAME_CONTROLLER -- requirements
Module: ps2_frame_controller

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16'd50000: the number of CLK cycles without a PS/2 falling edge before an in-progress frame is aborted.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: the number of decoded-code entries; it SHALL be a power of two.
REQ-003 SHALL have port CLK, input, 1 bit: system clock; the design has a single clock domain.
REQ-004 SHALL have port RST, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port ps2clk, input, 1 bit: raw PS/2 clock line, asynchronous to CLK.
REQ-006 SHALL have port ps2data, input, 1 bit: raw PS/2 data line, asynchronous to CLK.
REQ-007 SHALL have port code, output, 8 bits: scan code at the FIFO head.
REQ-008 SHALL have port code_brk, output, 1 bit: head code was preceded by the break prefix 0xF0.
REQ-009 SHALL have port code_ext, output, 1 bit: head code was preceded by the extended prefix 0xE0.
REQ-010 SHALL have port code_valid, output, 1 bit: FIFO is non-empty.
REQ-011 SHALL have port code_ready, input, 1 bit: consumer accepts the head entry.
REQ-012 SHALL have port frame_err, output, 1 bit: one-cycle pulse on any frame error.
REQ-013 SHALL have port overflow, output, 1 bit: sticky flag, set when a code is dropped because the FIFO is full.
REQ-014 SHALL have port busy, output, 1 bit: FSM is not in IDLE.

Function
REQ-015 SHALL pass ps2clk and ps2data through two-flop synchronizers; an edge is a synchronized ps2clk falling edge (previous sample 1, current sample 0).
REQ-016 SHALL implement FSM states IDLE, DATA, PARITY and STOP, advancing only on edges.
REQ-017 IDLE: on an edge with data=0, SHALL go to DATA with the bit count at 0; on an edge with data=1, SHALL pulse frame_err and remain in IDLE.
REQ-018 DATA: SHALL shift data LSB-first into the shift register on each edge; after the 8th bit, SHALL go to PARITY.
REQ-019 PARITY: SHALL capture the parity bit, then go to STOP.
REQ-020 STOP: on an edge, SHALL return to IDLE; if stop=1 and parity is good, the byte is accepted; otherwise it SHALL pulse frame_err and discard the byte.
REQ-021 Parity is good when the 8 data bits plus the parity bit contain an odd number of ones.
REQ-022 In any state other than IDLE, if the idle counter reaches TIMEOUT, SHALL return to IDLE, pulse frame_err, and clear the prefix flags; the counter SHALL reset on every edge.
REQ-023 An accepted 0xE0 SHALL set ext_pend; an accepted 0xF0 SHALL set brk_pend; no FIFO write occurs for either.
REQ-024 Any other accepted byte SHALL be written as {ext_pend, brk_pend, byte}, and both pend flags SHALL then clear.
REQ-025 The FIFO write SHALL occur on the CLK edge that registers the stop-bit edge, and code_valid SHALL rise on the next cycle if the FIFO was empty.
REQ-026 A pop SHALL occur on a cycle where code_valid && code_ready; code_ready while empty SHALL be ignored.
REQ-027 A write while full and not popping SHALL drop the entry and set overflow; a write while full with a simultaneous pop SHALL accept both.
REQ-028 Read and write pointers SHALL be log2(FIFO_DEPTH)+1 bits wide and wrap modulo 2*FIFO_DEPTH.
REQ-029 busy SHALL be high in DATA, PARITY and STOP.

Reset
REQ-030 While RST=1, SHALL hold FSM=IDLE and clear bit count, shift register, pend flags, timeout counter, FIFO pointers and synchronizers (to 1).
REQ-031 During reset, outputs SHALL be code=0, code_brk=0, code_ext=0, code_valid=0, frame_err=0, overflow=0, busy=0.
REQ-032 Reset asserted mid-frame SHALL abandon the frame with no FIFO write and no frame_err pulse.

Configuration
REQ-033 With macro PS2_PARITY_CHECK_EN defined, a parity failure SHALL cause frame_err and discard of the byte.
REQ-034 Without PS2_PARITY_CHECK_EN, the parity bit SHALL be sampled and ignored, and only start, stop and timeout errors SHALL raise frame_err.

Verification
REQ-035 Frame 0x1C, odd parity 0, stop 1, code_ready=1 -> single pop with code=0x1C, brk=0, ext=0, and frame_err never high.
REQ-036 Frames 0xF0 then 0x1C -> exactly one entry with code=0x1C, brk=1, ext=0.
REQ-037 Frames 0xE0, 0xF0, 0x75 -> exactly one entry with code=0x75, brk=1, ext=1; the next plain 0x74 frame gives brk=0, ext=0.
REQ-038 Frame 0x1C with parity bit 1 -> with the macro defined, one frame_err pulse and code_valid stays 0; without the macro, an entry 0x1C is written.
REQ-039 Five edges of a frame followed by ps2clk held high for TIMEOUT+10 cycles -> frame_err pulse, busy=0; the next 0x1C frame decodes correctly.
REQ-040 Six codes 0x15, 0x1D, 0x24, 0x2D, 0x2C, 0x35 with code_ready=0 -> four entries retained, overflow=1; pops return 0x15, 0x1D, 0x24, 0x2D in order.

Source files
------------

// File: rtl/ps2_frame_controller.sv
// ps2_frame_controller: decodes PS/2 device-to-host frames into a small FIFO of
// scan codes, with each code tagged by the break (0xF0) and extended (0xE0) prefixes.
// Ports: CLK, RST (async, active-high); ps2clk/ps2data raw lines; code/code_brk/
// code_ext/code_valid FIFO head with code_ready pop; frame_err pulse; overflow
// sticky flag; busy while a frame is in progress.
// Optional: define PS2_PARITY_CHECK_EN to reject frames with bad odd parity.
module ps2_frame_controller #(
  parameter logic [15:0] TIMEOUT    = 16'd50000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       ps2clk,
  input  logic       ps2data,
  output logic [7:0] code,
  output logic       code_brk,
  output logic       code_ext,
  output logic       code_valid,
  input  logic       code_ready,
  output logic       frame_err,
  output logic       overflow,
  output logic       busy
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  state_t state, state_nxt;

  logic        clk_s1, clk_s2, clk_prev, dat_s1, dat_s2;
  logic        edge_fall;
  logic [2:0]  bit_cnt;
  logic [7:0]  shreg;
  logic        ext_pend, brk_pend;
  logic [15:0] idle_cnt;
  logic        timeout_hit, shift_en, byte_ok, err_nxt, par_pass;
  logic        push, pop, full, wr_en;
  logic [AW:0] wr_ptr, rd_ptr;
  logic [9:0]  mem [FIFO_DEPTH];
  logic [9:0]  head;

  assign edge_fall   = clk_prev & ~clk_s2;
  assign timeout_hit = (state != IDLE) && (idle_cnt == TIMEOUT);
  assign busy        = (state != IDLE);

`ifdef PS2_PARITY_CHECK_EN
  logic par_bit;
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                              par_bit <= 1'b0;
    else if (state == PARITY && edge_fall) par_bit <= dat_s2;
  end
  assign par_pass = ^{shreg, par_bit};
`else
  assign par_pass = 1'b1;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    shift_en  = 1'b0;
    byte_ok   = 1'b0;
    err_nxt   = 1'b0;
    if (timeout_hit) begin
      state_nxt = IDLE;
      err_nxt   = 1'b1;
    end else if (edge_fall) begin
      case (state)
        IDLE: begin
          if (!dat_s2) state_nxt = DATA;
          else         err_nxt   = 1'b1;
        end
        DATA: begin
          shift_en = 1'b1;
          if (bit_cnt == 3'd7) state_nxt = PARITY;
        end
        PARITY: state_nxt = STOP;
        STOP: begin
          state_nxt = IDLE;
          if (dat_s2 && par_pass) byte_ok = 1'b1;
          else                    err_nxt = 1'b1;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign push  = byte_ok && (shreg != 8'hE0) && (shreg != 8'hF0);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = code_valid && code_ready;
  assign wr_en = push && (!full || pop);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      clk_s1    <= 1'b1;
      clk_s2    <= 1'b1;
      clk_prev  <= 1'b1;
      dat_s1    <= 1'b1;
      dat_s2    <= 1'b1;
      bit_cnt   <= '0;
      shreg     <= '0;
      ext_pend  <= 1'b0;
      brk_pend  <= 1'b0;
      idle_cnt  <= '0;
      frame_err <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      clk_s1    <= ps2clk;
      clk_s2    <= clk_s1;
      clk_prev  <= clk_s2;
      dat_s1    <= ps2data;
      dat_s2    <= dat_s1;
      frame_err <= err_nxt;
      if (state_nxt == IDLE || edge_fall) idle_cnt <= '0;
      else                                idle_cnt <= idle_cnt + 16'd1;
      if (state == IDLE && state_nxt == DATA) bit_cnt <= '0;
      if (shift_en) begin
        shreg   <= {dat_s2, shreg[7:1]};
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (timeout_hit) begin
        ext_pend <= 1'b0;
        brk_pend <= 1'b0;
      end else if (byte_ok) begin
        case (shreg)
          8'hE0:   ext_pend <= 1'b1;
          8'hF0:   brk_pend <= 1'b1;
          default: begin
            ext_pend <= 1'b0;
            brk_pend <= 1'b0;
          end
        endcase
      end
      if (push && full && !pop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)   rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= {ext_pend, brk_pend, shreg};
  end

  // storage is not reset, so the head is masked until an entry exists
  assign code_valid = (wr_ptr != rd_ptr);
  assign head       = mem[rd_ptr[AW-1:0]];
  assign code       = code_valid ? head[7:0] : '0;
  assign code_brk   = code_valid & head[8];
  assign code_ext   = code_valid & head[9];

endmodule

// File: tb/tb_ps2_frame_controller.sv
module tb_ps2_frame_controller;

  localparam logic [15:0] TO   = 16'd200;
  localparam int          HALF = 8;
  localparam int          DEPTH = 4;
`ifdef PS2_PARITY_CHECK_EN
  localparam bit PAR_CHK = 1'b1;
`else
  localparam bit PAR_CHK = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RST, ps2clk, ps2data, code_ready;
  logic [7:0] code;
  logic       code_brk, code_ext, code_valid, frame_err, overflow, busy;

  always #5 CLK = ~CLK;

  ps2_frame_controller #(.TIMEOUT(TO), .FIFO_DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST), .ps2clk(ps2clk), .ps2data(ps2data),
    .code(code), .code_brk(code_brk), .code_ext(code_ext),
    .code_valid(code_valid), .code_ready(code_ready),
    .frame_err(frame_err), .overflow(overflow), .busy(busy)
  );

  int checks = 0, errors = 0;
  int fe_cnt = 0, fe_base = 0, exp_fe = 0;
  logic [9:0] q[$];
  bit m_ext, m_brk, m_ovf;

  always @(negedge CLK) if (frame_err === 1'b1) fe_cnt++;

  function automatic logic odd_par(input logic [7:0] b);
    return ~^b;
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic ps2_bit(input logic d, input bit pop_at_edge);
    ps2data = d;
    wait_cyc(HALF);
    ps2clk = 1'b0;
    if (pop_at_edge) begin
      wait_cyc(2);
      code_ready = 1'b1;
      wait_cyc(1);
      code_ready = 1'b0;
      wait_cyc(HALF - 3);
    end else wait_cyc(HALF);
    ps2clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par, input logic stp, input bit pop_at_stop);
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i], 1'b0);
    ps2_bit(par, 1'b0);
    ps2_bit(stp, pop_at_stop);
    ps2data = 1'b1;
    wait_cyc(4);
  endtask

  // reference: what the controller should have done with one whole frame
  task automatic model_frame(input logic [7:0] b, input logic par, input logic stp);
    bit par_good = ($countones({b, par}) % 2) == 1;
    bit ok = stp && (par_good || !PAR_CHK);
    if (!ok) exp_fe++;
    else if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_brk = 1'b1;
    else begin
      if (q.size() < DEPTH) q.push_back({m_ext, m_brk, b});
      else m_ovf = 1'b1;
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  task automatic frame(input logic [7:0] b);
    send_frame(b, odd_par(b), 1'b1, 1'b0);
    model_frame(b, odd_par(b), 1'b1);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    wait_cyc(3);
    RST = 1'b0;
    wait_cyc(2);
    q.delete();
    m_ext = 0; m_brk = 0; m_ovf = 0;
  endtask

  task automatic test_reset();
    RST = 1'b1; ps2clk = 1'b1; ps2data = 1'b1; code_ready = 1'b0;
    wait_cyc(3);
    checks++;
    if ({code, code_brk, code_ext, code_valid, frame_err, overflow, busy} !== 14'd0) begin
      errors++; $display("FAIL reset_outputs: got %h required 0", {code, code_brk, code_ext, code_valid, frame_err, overflow, busy});
    end
    ps2data = 1'b0; ps2clk = 1'b0; wait_cyc(4);
    checks++;
    if (busy !== 1'b0 || frame_err !== 1'b0) begin
      errors++; $display("FAIL reset_hold_idle: busy=%b frame_err=%b required 0 0", busy, frame_err);
    end
    ps2clk = 1'b1; ps2data = 1'b1;
    RST = 1'b0;
    wait_cyc(4);
    q.delete(); m_ext = 0; m_brk = 0; m_ovf = 0;
    fe_base = fe_cnt; exp_fe = 0;
    ps2_bit(1'b0, 1'b0); ps2_bit(1'b1, 1'b0); ps2_bit(1'b0, 1'b0); ps2_bit(1'b1, 1'b0);
    wait_cyc(3);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL midframe_busy: got %b required 1", busy); end
    RST = 1'b1; wait_cyc(2); RST = 1'b0; wait_cyc(TO + 10);
    checks++;
    if ({code_valid, busy} !== 2'b00 || fe_cnt - fe_base != 0) begin
      errors++; $display("FAIL midframe_reset: valid=%b busy=%b frame_errs=%0d required 0 0 0", code_valid, busy, fe_cnt - fe_base);
    end
  endtask

  task automatic test_basic();
    fe_base = fe_cnt; exp_fe = 0;
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    model_frame(8'h1C, 1'b0, 1'b1);
    checks++;
    if (code_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b required 1", code_valid); end
    while (q.size() != 0) begin
      checks++;
      if ({code_ext, code_brk, code} !== q[0]) begin
        errors++; $display("FAIL basic_pop: got %h required %h", {code_ext, code_brk, code}, q[0]);
      end
      void'(q.pop_front()); code_ready = 1'b1; wait_cyc(1); code_ready = 1'b0; wait_cyc(1);
    end
    checks++;
    if (code_valid !== 1'b0 || fe_cnt - fe_base != 0) begin
      errors++; $display("FAIL basic_after: valid=%b frame_errs=%0d required 0 0", code_valid, fe_cnt - fe_base);
    end
  endtask

  task automatic test_prefixes();
    fe_base = fe_cnt; exp_fe = 0;
    frame(8'hF0); frame(8'h1C);
    frame(8'hE0); frame(8'hF0); frame(8'h75);
    frame(8'h74);
    checks++;
    if (q.size() != 3 || q[0] !== {2'b01, 8'h1C} || q[1] !== {2'b11, 8'h75} || q[2] !== {2'b00, 8'h74}) begin
      errors++; $display("FAIL prefix_model: model queue size %0d differs from required 3", q.size());
    end
    while (q.size() != 0) begin
      checks++;
      if (code_valid !== 1'b1 || {code_ext, code_brk, code} !== q[0]) begin
        errors++; $display("FAIL prefix_pop: got v=%b %h required v=1 %h", code_valid, {code_ext, code_brk, code}, q[0]);
      end
      void'(q.pop_front()); code_ready = 1'b1; wait_cyc(1); code_ready = 1'b0; wait_cyc(1);
    end
    checks++;
    if (code_valid !== 1'b0 || fe_cnt - fe_base != exp_fe) begin
      errors++; $display("FAIL prefix_after: valid=%b frame_errs=%0d required 0 %0d", code_valid, fe_cnt - fe_base, exp_fe);
    end
  endtask

  task automatic test_errors();
    fe_base = fe_cnt; exp_fe = 0;
    send_frame(8'h1C, 1'b1, 1'b1, 1'b0);
    model_frame(8'h1C, 1'b1, 1'b1);
    checks++;
    if (code_valid !== (q.size() != 0) || fe_cnt - fe_base != exp_fe) begin
      errors++; $display("FAIL parity_bad: valid=%b frame_errs=%0d required %b %0d", code_valid, fe_cnt - fe_base, q.size() != 0, exp_fe);
    end
    if (q.size() != 0) begin
      checks++;
      if ({code_ext, code_brk, code} !== q[0]) begin
        errors++; $display("FAIL parity_entry: got %h required %h", {code_ext, code_brk, code}, q[0]);
      end
      void'(q.pop_front()); code_ready = 1'b1; wait_cyc(1); code_ready = 1'b0; wait_cyc(1);
    end
    ps2_bit(1'b1, 1'b0); exp_fe++; wait_cyc(4);
    checks++;
    if (busy !== 1'b0 || fe_cnt - fe_base != exp_fe) begin
      errors++; $display("FAIL start_err: busy=%b frame_errs=%0d required 0 %0d", busy, fe_cnt - fe_base, exp_fe);
    end
    send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
    model_frame(8'h1C, 1'b0, 1'b0);
    checks++;
    if (code_valid !== 1'b0 || fe_cnt - fe_base != exp_fe) begin
      errors++; $display("FAIL stop_err: valid=%b frame_errs=%0d required 0 %0d", code_valid, fe_cnt - fe_base, exp_fe);
    end
  endtask

  task automatic test_timeout();
    fe_base = fe_cnt; exp_fe = 0;
    frame(8'hF0);
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1, 1'b0);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL timeout_busy: got %b required 1", busy); end
    wait_cyc(TO + 10);
    exp_fe++; m_ext = 0; m_brk = 0;
    checks++;
    if (busy !== 1'b0 || fe_cnt - fe_base != exp_fe) begin
      errors++; $display("FAIL timeout_abort: busy=%b frame_errs=%0d required 0 %0d", busy, fe_cnt - fe_base, exp_fe);
    end
    frame(8'h1C);
    checks++;
    if (code_valid !== 1'b1 || {code_ext, code_brk, code} !== {2'b00, 8'h1C}) begin
      errors++; $display("FAIL timeout_next: got v=%b %h required v=1 01c", code_valid, {code_ext, code_brk, code});
    end
    void'(q.pop_front()); code_ready = 1'b1; wait_cyc(1); code_ready = 1'b0; wait_cyc(1);
  endtask

  task automatic test_full_pop();
    logic [7:0] codes [4] = '{8'h15, 8'h1D, 8'h24, 8'h2D};
    for (int i = 0; i < 4; i++) frame(codes[i]);
    send_frame(8'h2C, odd_par(8'h2C), 1'b1, 1'b1);
    void'(q.pop_front());
    model_frame(8'h2C, odd_par(8'h2C), 1'b1);
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL full_pop_ovf: got %b required 0", overflow); end
    while (q.size() != 0) begin
      checks++;
      if (code_valid !== 1'b1 || {code_ext, code_brk, code} !== q[0]) begin
        errors++; $display("FAIL full_pop_order: got v=%b %h required v=1 %h", code_valid, {code_ext, code_brk, code}, q[0]);
      end
      void'(q.pop_front()); code_ready = 1'b1; wait_cyc(1); code_ready = 1'b0; wait_cyc(1);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] codes [6] = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35};
    for (int i = 0; i < 6; i++) frame(codes[i]);
    checks++;
    if (overflow !== 1'b1 || m_ovf !== 1'b1 || q.size() != 4) begin
      errors++; $display("FAIL overflow_flag: got %b required 1", overflow);
    end
    while (q.size() != 0) begin
      checks++;
      if (code_valid !== 1'b1 || {code_ext, code_brk, code} !== q[0]) begin
        errors++; $display("FAIL overflow_order: got v=%b %h required v=1 %h", code_valid, {code_ext, code_brk, code}, q[0]);
      end
      void'(q.pop_front()); code_ready = 1'b1; wait_cyc(1); code_ready = 1'b0; wait_cyc(1);
    end
    checks++;
    if (code_valid !== 1'b0 || overflow !== 1'b1) begin
      errors++; $display("FAIL overflow_after: valid=%b ovf=%b required 0 1", code_valid, overflow);
    end
  endtask

  task automatic test_random();
    logic [7:0] b;
    logic par, stp;
    do_reset();
    fe_base = fe_cnt; exp_fe = 0;
    for (int n = 0; n < 30; n++) begin
      case ($urandom_range(0, 7))
        0:       b = 8'hE0;
        1:       b = 8'hF0;
        default: b = 8'($urandom_range(0, 255));
      endcase
      par = odd_par(b) ^ ($urandom_range(0, 5) == 0);
      stp = ($urandom_range(0, 7) != 0);
      send_frame(b, par, stp, 1'b0);
      model_frame(b, par, stp);
      checks++;
      if (code_valid !== (q.size() != 0) || overflow !== m_ovf || fe_cnt - fe_base != exp_fe) begin
        errors++; $display("FAIL rand_state: frame %0d valid=%b ovf=%b errs=%0d required %b %b %0d",
                           n, code_valid, overflow, fe_cnt - fe_base, q.size() != 0, m_ovf, exp_fe);
      end
      if ($urandom_range(0, 2) == 0 || n == 29) begin
        while (q.size() != 0) begin
          checks++;
          if (code_valid !== 1'b1 || {code_ext, code_brk, code} !== q[0]) begin
            errors++; $display("FAIL rand_pop: got v=%b %h required v=1 %h", code_valid, {code_ext, code_brk, code}, q[0]);
          end
          void'(q.pop_front()); code_ready = 1'b1; wait_cyc(1); code_ready = 1'b0; wait_cyc(1);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_prefixes();
    test_errors();
    test_timeout();
    test_full_pop();
    test_overflow();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
